gpu_rect_fill: RTL and testbench
================================

Name: gpu_rect_fill

Overview:
- Rectangle fill engine, directly upstream of the VGA scan-out stage.
- Accepts one fill command at a time from the CPU-side GPU register block.
- Writes the 8-bit colour into every pixel of an inclusive rectangle of the 256x256 framebuffer.
- Uses the same {y[7:0], x[7:0]} addressing and colour packing (blue [7:4], green [3:0]) that scan-out reads.

Parameters:
- COORD_W, 8, width of x and y coordinates.
- ADDR_W, 16, framebuffer address width; always 2*COORD_W.
- WAIT_VBLANK, 1, when 1 the engine holds each accepted command until vblank is high before writing.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle, can accept a command.
- cmd_x0, cmd_x1  in  8 each  horizontal corners, inclusive, any order.
- cmd_y0, cmd_y1  in  8 each  vertical corners, inclusive, any order.
- cmd_color  in  8  fill colour, blue [7:4], green [3:0].
- vblank  in  1  high outside the visible frame (from the timing generator).
- fb_req  out  1  write request to the framebuffer arbiter.
- fb_gnt  in  1  arbiter grant; a write commits on a cycle with fb_req && fb_gnt.
- fb_addr  out  16  {cur_y, cur_x}.
- fb_wdata  out  8  latched colour.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last pixel has committed.

Behaviour:
- Reset values: cmd_ready=1 once out of reset, fb_req=0, fb_addr=0, fb_wdata=0, busy=0, done=0. State goes to IDLE.
- Reset mid-fill: the fill is abandoned immediately. No further writes occur and no done pulse is produced.
- FSM states: IDLE, WAIT_VB, FILL, DONE.
- Command acceptance:
  - cmd_ready = (state==IDLE). A command is accepted on a cycle with cmd_valid && cmd_ready.
  - On accept, the engine registers xmin=min(x0,x1), xmax=max(x0,x1), ymin=min(y0,y1), ymax=max(y0,y1) and the colour.
  - On accept, cur_x=xmin and cur_y=ymin.
- IDLE -> WAIT_VB if WAIT_VBLANK=1 and vblank=0 in the accept cycle; otherwise IDLE -> FILL.
- WAIT_VB -> FILL on the first cycle vblank=1. The engine never re-waits mid-fill; tearing across one frame is acceptable.
- FILL:
  - fb_req=1. fb_addr and fb_wdata come from registers (no combinational path from cmd_*).
  - On a commit cycle: if cur_x!=xmax, cur_x++. Else cur_x=xmin and cur_y++. If also cur_y==ymax, go to DONE.
  - Comparisons are made before increment, so xmax=255 or ymax=255 never wraps the 8-bit counters.
  - fb_gnt=0 stalls: address, data and counters hold, and fb_req stays high.
- DONE: done=1 and fb_req=0 for exactly one cycle, then IDLE.
  - cmd_ready rises in the cycle after done, so back-to-back commands have a 1-cycle gap minimum.
- Latency with fb_gnt held high and no vblank wait:
  - Accept at cycle N, first write at N+1, last write at N+W*H, done at N+W*H+1.
  - W = xmax-xmin+1, H = ymax-ymin+1.
- Degenerate case: x0==x1 and y0==y1 produces exactly one write.
- Full screen (0,0)-(255,255) produces 65536 writes.
- cmd_* inputs are ignored while busy.

Decomposition:
- gpu_pkg holds:
  - COORD_W and FB_ADDR_W constants.
  - The state enum (IDLE, WAIT_VB, FILL, DONE).
  - The pixel colour field positions (BLUE_HI=7, BLUE_LO=4, GREEN_HI=3, GREEN_LO=0), shared with scan-out.
- No sub-module is needed. The min/max normalisation is a small function in gpu_pkg.

Test Plan:
- Single pixel: cmd (5,7)-(5,7), colour 0xA3, gnt=1, WAIT_VBLANK=0 -> exactly one write, addr 0x0705, data 0xA3, done at accept+2.
- Swapped corners: x0=10, x1=8, y0=2, y1=1 -> 6 writes, in order 0x0108, 0x0109, 0x010A, 0x0208, 0x0209, 0x020A, then done.
- Full screen: (0,0)-(255,255), gnt=1 -> 65536 writes, last addr 0xFFFF, no wrap back to 0x0000, done at accept+65537.
- Grant stall: fill (0,0)-(3,0) with gnt low for 3 cycles during the 2nd pixel -> addr 0x0001 held for 3 cycles, 4 commits total, done delayed 3 cycles.
- Vblank gating: WAIT_VBLANK=1, accept with vblank=0, raise vblank 20 cycles later -> no fb_req before vblank rises, first write the cycle after.
- Reset mid-fill: assert rst during the 3rd write of a 4x4 fill -> next cycle fb_req=0, busy=0, cmd_ready=1, no done pulse; a new command is accepted normally afterwards.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: framebuffer geometry, pixel colour layout and the
// rectangle-fill state encoding, used by the fill engine and by scan-out.
package gpu_pkg;

  localparam int COORD_W   = 8;
  localparam int FB_ADDR_W = 2 * COORD_W;

  // Colour byte layout, must match what scan-out decodes.
  localparam int BLUE_HI  = 7;
  localparam int BLUE_LO  = 4;
  localparam int GREEN_HI = 3;
  localparam int GREEN_LO = 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    FILL,
    DONE
  } fill_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;
  } span_t;

  // Corners arrive in any order; normalise to an ascending inclusive span.
  function automatic span_t order_span(input logic [COORD_W-1:0] a,
                                       input logic [COORD_W-1:0] b);
    span_t s;
    s.lo = (a < b) ? a : b;
    s.hi = (a < b) ? b : a;
    return s;
  endfunction

endpackage

// File: rtl/gpu_rect_fill_if.sv
// Command, framebuffer-write and status signals of the rectangle fill engine.
// master = CPU register block / arbiter side, slave = fill engine.
interface gpu_rect_fill_if #(
  parameter int COORD_W = gpu_pkg::COORD_W,
  parameter int ADDR_W  = gpu_pkg::FB_ADDR_W
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x0;
  logic [COORD_W-1:0] cmd_x1;
  logic [COORD_W-1:0] cmd_y0;
  logic [COORD_W-1:0] cmd_y1;
  logic [7:0]         cmd_color;
  logic               vblank;
  logic               fb_req;
  logic               fb_gnt;
  logic [ADDR_W-1:0]  fb_addr;
  logic [7:0]         fb_wdata;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, vblank, fb_gnt,
    input  cmd_ready, fb_req, fb_addr, fb_wdata, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, vblank, fb_gnt,
    output cmd_ready, fb_req, fb_addr, fb_wdata, busy, done
  );

endinterface

// File: rtl/gpu_rect_fill.sv
// Rectangle fill engine: writes one colour into every pixel of an inclusive
// rectangle of the 256x256 framebuffer, row by row, one pixel per grant.
module gpu_rect_fill #(
  parameter int COORD_W     = gpu_pkg::COORD_W,
  parameter int ADDR_W      = gpu_pkg::FB_ADDR_W,
  parameter bit WAIT_VBLANK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  gpu_rect_fill_if.slave bus
);
  import gpu_pkg::*;

  fill_state_t state, state_nxt;

  logic [COORD_W-1:0] xmin, xmax, ymax;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [7:0]         color_q;

  span_t x_span, y_span;
  logic  accept, commit, last_pix;

  assign x_span   = order_span(bus.cmd_x0, bus.cmd_x1);
  assign y_span   = order_span(bus.cmd_y0, bus.cmd_y1);
  assign accept   = bus.cmd_valid && (state == IDLE);
  assign commit   = (state == FILL) && bus.fb_gnt;
  assign last_pix = (cur_x == xmax) && (cur_y == ymax);

  assign bus.fb_addr  = ADDR_W'({cur_y, cur_x});
  assign bus.fb_wdata = color_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.fb_req    = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid)
          state_nxt = (WAIT_VBLANK && !bus.vblank) ? WAIT_VB : FILL;
      end
      // Vblank is only waited for once per command; a long fill may tear.
      WAIT_VB: if (bus.vblank) state_nxt = FILL;
      FILL: begin
        bus.fb_req = 1'b1;
        if (bus.fb_gnt && last_pix) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Rectangle bounds are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      xmin <= x_span.lo;
      xmax <= x_span.hi;
      ymax <= y_span.hi;
    end
  end

  // Counters compare before incrementing so a bound of 255 never wraps them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x   <= '0;
      cur_y   <= '0;
      color_q <= '0;
    end else if (accept) begin
      cur_x   <= x_span.lo;
      cur_y   <= y_span.lo;
      color_q <= {bus.cmd_color[BLUE_HI:BLUE_LO], bus.cmd_color[GREEN_HI:GREEN_LO]};
    end else if (commit) begin
      if (cur_x != xmax) begin
        cur_x <= cur_x + 1'b1;
      end else begin
        cur_x <= xmin;
        if (cur_y != ymax) cur_y <= cur_y + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Bench for gpu_rect_fill: table of rectangles checked through a write
// scoreboard, plus hand sequences for stalls, vblank gating and reset.
module tb_gpu_rect_fill;

  typedef struct {
    logic [7:0]  x0, x1, y0, y1, color;
    int          exp_writes;
    logic [15:0] exp_first, exp_last;
  } vec_t;

  vec_t vecs[5];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] sb_q[$];
  int          nwr      = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [15:0] first_addr = '0;
  logic [15:0] last_addr  = '0;

  gpu_rect_fill_if bus0();
  gpu_rect_fill_if bus1();

  gpu_rect_fill #(.WAIT_VBLANK(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  gpu_rect_fill #(.WAIT_VBLANK(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Write monitor and scoreboard for dut0.
  always @(negedge clk) begin
    logic [23:0] e;
    if (bus0.fb_req && bus0.fb_gnt) begin
      if (nwr == 0) first_addr = bus0.fb_addr;
      last_addr = bus0.fb_addr;
      nwr++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%04h, required no write", bus0.fb_addr);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(bus0.fb_addr), 32'(e[23:8]));
        check("wr_data", 32'(bus0.fb_wdata), 32'(e[7:0]));
      end
    end
    if (bus0.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic push_rect(input logic [7:0] x0, x1, y0, y1, col);
    int xl, xh, yl, yh;
    xl = (x0 < x1) ? int'(x0) : int'(x1);
    xh = (x0 < x1) ? int'(x1) : int'(x0);
    yl = (y0 < y1) ? int'(y0) : int'(y1);
    yh = (y0 < y1) ? int'(y1) : int'(y0);
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        sb_q.push_back({8'(y), 8'(x), col});
  endtask

  task automatic send_cmd(input logic [7:0] x0, x1, y0, y1, col, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(posedge clk); #1;
    bus0.cmd_x0 = x0; bus0.cmd_x1 = x1;
    bus0.cmd_y0 = y0; bus0.cmd_y1 = y1;
    bus0.cmd_color = col;
    bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (bus0.cmd_ready) begin
        got = 1'b1;
        acc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    if (!got) fail_now("accept_timeout");
  endtask

  task automatic wait_done(input int d0, input int budget, output int dc);
    bit seen;
    seen = 1'b0;
    dc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        dc = done_cyc;
      end
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic run_rect(input string tag, input logic [7:0] x0, x1, y0, y1, col,
                          input int exp_w, input logic [15:0] ef, input logic [15:0] el);
    int acc, dc, d0;
    @(posedge clk); #1;
    nwr = 0;
    d0 = done_cnt;
    push_rect(x0, x1, y0, y1, col);
    send_cmd(x0, x1, y0, y1, col, acc);
    wait_done(d0, exp_w + 20, dc);
    check({tag, "_latency"}, 32'(dc - acc), 32'(exp_w + 1));
    check({tag, "_writes"}, 32'(nwr), 32'(exp_w));
    check({tag, "_first"}, 32'(first_addr), 32'(ef));
    check({tag, "_last"}, 32'(last_addr), 32'(el));
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_ready_after"}, 32'(bus0.cmd_ready), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dc, d0, early, vb;

    vecs[0] = '{8'd5,   8'd5,   8'd7,   8'd7,   8'hA3, 1,  16'h0705, 16'h0705};
    vecs[1] = '{8'd10,  8'd8,   8'd2,   8'd1,   8'h5C, 6,  16'h0108, 16'h020A};
    vecs[2] = '{8'd255, 8'd252, 8'd10,  8'd10,  8'hF0, 4,  16'h0AFC, 16'h0AFF};
    vecs[3] = '{8'd200, 8'd203, 8'd255, 8'd250, 8'h0F, 24, 16'hFAC8, 16'hFFCB};
    vecs[4] = '{8'd0,   8'd0,   8'd3,   8'd0,   8'h11, 4,  16'h0000, 16'h0300};

    bus0.cmd_valid = 1'b0; bus0.cmd_x0 = '0; bus0.cmd_x1 = '0;
    bus0.cmd_y0 = '0; bus0.cmd_y1 = '0; bus0.cmd_color = '0;
    bus0.vblank = 1'b0; bus0.fb_gnt = 1'b1;
    bus1.cmd_valid = 1'b0; bus1.cmd_x0 = '0; bus1.cmd_x1 = '0;
    bus1.cmd_y0 = '0; bus1.cmd_y1 = '0; bus1.cmd_color = '0;
    bus1.vblank = 1'b0; bus1.fb_gnt = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    check("rst_fb_req", 32'(bus0.fb_req), 32'd0);
    check("rst_fb_addr", 32'(bus0.fb_addr), 32'd0);
    check("rst_fb_wdata", 32'(bus0.fb_wdata), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_vb_cmd_ready", 32'(bus1.cmd_ready), 32'd1);

    for (int i = 0; i < 5; i++)
      run_rect($sformatf("vec%0d", i), vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
               vecs[i].color, vecs[i].exp_writes, vecs[i].exp_first, vecs[i].exp_last);

    run_rect("full", 8'd0, 8'd255, 8'd0, 8'd255, 8'h5A, 65536, 16'h0000, 16'hFFFF);

    // Grant stall on the second pixel, with a command offered while busy.
    @(posedge clk); #1;
    nwr = 0;
    d0 = done_cnt;
    push_rect(8'd0, 8'd3, 8'd0, 8'd0, 8'h77);
    send_cmd(8'd0, 8'd3, 8'd0, 8'd0, 8'h77, acc);
    @(posedge clk); #1;
    bus0.fb_gnt = 1'b0;
    bus0.cmd_x0 = 8'd9; bus0.cmd_x1 = 8'd9; bus0.cmd_y0 = 8'd9; bus0.cmd_y1 = 8'd9;
    bus0.cmd_color = 8'hEE;
    bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("stall_addr", 32'(bus0.fb_addr), 32'h0001);
      check("stall_req", 32'(bus0.fb_req), 32'd1);
      check("stall_ready", 32'(bus0.cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus0.fb_gnt = 1'b1;
    bus0.cmd_valid = 1'b0;
    wait_done(d0, 40, dc);
    check("stall_latency", 32'(dc - acc), 32'd8);
    check("stall_writes", 32'(nwr), 32'd4);
    check("stall_last", 32'(last_addr), 32'h0003);
    check("stall_sb_empty", 32'(sb_q.size()), 32'd0);

    // Vblank gating on the WAIT_VBLANK=1 instance.
    @(posedge clk); #1;
    bus1.cmd_x0 = 8'd3; bus1.cmd_x1 = 8'd2; bus1.cmd_y0 = 8'd4; bus1.cmd_y1 = 8'd4;
    bus1.cmd_color = 8'hC3;
    bus1.cmd_valid = 1'b1;
    @(negedge clk); #1;
    check("vb_accept_ready", 32'(bus1.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus1.cmd_valid = 1'b0;
    early = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus1.fb_req) early++;
      @(posedge clk); #1;
    end
    check("vb_no_early_req", 32'(early), 32'd0);
    check("vb_busy_wait", 32'(bus1.busy), 32'd1);
    bus1.vblank = 1'b1;
    vb = cyc;
    @(negedge clk); #1;
    check("vb_req_edge", 32'(bus1.fb_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("vb_first_cycle", 32'(cyc - vb), 32'd1);
    check("vb_first_req", 32'(bus1.fb_req), 32'd1);
    check("vb_first_addr", 32'(bus1.fb_addr), 32'h0402);
    check("vb_first_data", 32'(bus1.fb_wdata), 32'h00C3);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("vb_second_addr", 32'(bus1.fb_addr), 32'h0403);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("vb_done", 32'(bus1.done), 32'd1);
    check("vb_done_req", 32'(bus1.fb_req), 32'd0);
    bus1.vblank = 1'b0;

    // Reset during the third write of a 4x4 fill.
    @(posedge clk); #1;
    nwr = 0;
    d0 = done_cnt;
    sb_q.push_back({16'h0000, 8'h3C});
    sb_q.push_back({16'h0001, 8'h3C});
    sb_q.push_back({16'h0002, 8'h3C});
    send_cmd(8'd0, 8'd3, 8'd0, 8'd3, 8'h3C, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("mrst_fb_req", 32'(bus0.fb_req), 32'd0);
    check("mrst_busy", 32'(bus0.busy), 32'd0);
    check("mrst_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    check("mrst_fb_addr", 32'(bus0.fb_addr), 32'd0);
    check("mrst_fb_wdata", 32'(bus0.fb_wdata), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mrst_writes", 32'(nwr), 32'd3);
    check("mrst_sb_empty", 32'(sb_q.size()), 32'd0);
    run_rect("after_rst", 8'd1, 8'd1, 8'd1, 8'd1, 8'h42, 1, 16'h0101, 16'h0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
